// File: rtl/uart_tx_stim.sv
// ============================================================================
// uart_tx_stim
// ----------------------------------------------------------------------------
// UART 8N1 transmitter used as a stimulus source: it drives a core's serial
// receive input so a bench (or an FPGA loopback) can inject console bytes.
// Bytes arrive over a valid/ready handshake into a small circular FIFO. They
// are then serialized LSB first at CLK_FREQ_HZ / BAUD clocks per bit, with the
// divider rounded to the nearest integer.
//
// Parameters
//   CLK_FREQ_HZ  clock frequency of clk in Hz
//   BAUD         serial line rate in bits per second
//   FIFO_DEPTH   byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk      in   single clock
//   rst      in   asynchronous, active-high reset
//   i_data   in   [7:0] byte to transmit
//   i_valid  in   i_data is valid
//   o_ready  out  FIFO can accept a byte (low during reset and when full)
//   o_tx     out  registered serial line, idle high
//   o_busy   out  a frame is in flight or the FIFO holds bytes
//   o_level  out  FIFO occupancy, 0..FIFO_DEPTH
// ============================================================================
module uart_tx_stim #(
   parameter int CLK_FREQ_HZ = 12_500_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

   // Elaboration guards: a divider below 2 cannot form a bit period, and the
   // wrapping pointer scheme needs a power-of-two depth.
   generate
      if (DIV < 2) begin : g_bad_div
         $error("uart_tx_stim: clocks per bit must be at least 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("uart_tx_stim: FIFO_DEPTH must be a power of two and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t          state_q,  state_d;
   logic [CW-1:0]   baud_q,   baud_d;
   logic [2:0]      bit_q,    bit_d;
   logic [7:0]      shift_q,  shift_d;
   logic            tx_q,     tx_d;
   logic [LW-1:0]   wr_ptr_q;
   logic [LW-1:0]   rd_ptr_q;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic [LW-1:0]   level;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            baud_done;
   logic [7:0]      head;

   // ------------------------------------------------------------------------
   // FIFO status and handshake
   // ------------------------------------------------------------------------
   // Pointers carry one extra bit so that full and empty are distinct; the
   // difference is the occupancy directly.
   assign level      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (level == '0);
   // Readiness looks only at the current level, so a pop in the same cycle
   // never lets a push into a full FIFO.
   assign o_ready    = !rst && (level < DEPTH_L);
   assign push       = i_valid && o_ready;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign baud_done  = (baud_q == BAUD_LAST);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      // The bit-period counter free-runs in every active state and wraps at
      // the end of each period.
      if (state_q != S_IDLE) begin
         baud_d = baud_done ? '0 : baud_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (baud_done) begin
               tx_d    = shift_q[0];
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            // shift_q[0] is always the bit currently on the line.
            if (baud_done) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end

         S_STOP: begin
            if (baud_done) begin
               // Chain straight into the next start bit so back-to-back
               // frames have no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control registers (asynchronous reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + LW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + LW'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Data registers (no reset; contents are meaningless once pointers clear)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= i_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_tx    = tx_q;
   assign o_busy  = (state_q != S_IDLE) || !fifo_empty;
   assign o_level = level;

endmodule

// File: tb/tb_uart_tx_stim.sv
module tb_uart_tx_stim;

   localparam int DIV   = 10;
   localparam int FRAME = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] i_data  = 8'h00;
   logic       i_valid = 1'b0;
   logic       o_ready;
   logic       o_tx;
   logic       o_busy;
   logic [2:0] o_level;

   logic [7:0] d2_data  = 8'h00;
   logic       d2_valid = 1'b0;
   logic       d2_ready;
   logic       d2_tx;
   logic       d2_busy;
   logic [3:0] d2_level;

   uart_tx_stim #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD        (100_000),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_tx    (o_tx),
      .o_busy  (o_busy),
      .o_level (o_level)
   );

   uart_tx_stim dut_def (
      .clk     (clk),
      .rst     (rst),
      .i_data  (d2_data),
      .i_valid (d2_valid),
      .o_ready (d2_ready),
      .o_tx    (d2_tx),
      .o_busy  (d2_busy),
      .o_level (d2_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   function automatic logic exp_bit(input logic [7:0] b, input int t);
      int slot;
      slot = t / DIV;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   // Receiver model: captures each frame sample by sample and compares it with
   // the byte at the head of the scoreboard.
   initial begin : rx_mon
      logic [7:0]  exp_b;
      logic [7:0]  got;
      logic [99:0] smp;
      logic        have_exp;
      logic        abort;
      int          bad;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || o_tx !== 1'b0) continue;
         start_q.push_back(cyc);
         frames++;
         have_exp = (exp_q.size() > 0);
         exp_b    = have_exp ? exp_q.pop_front() : 8'h00;
         abort    = 1'b0;
         smp      = '0;
         for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            if (rst !== 1'b0) begin
               abort = 1'b1;
               break;
            end
            smp[t] = o_tx;
         end
         if (!abort) begin
            for (int i = 0; i < 8; i++) got[i] = smp[(i + 1) * DIV + DIV / 2];
            checks++;
            if (!have_exp) begin
               errors++;
               $display("FAIL rx_unexpected: frame with byte %02h at cycle %0d, required no frame", got, cyc);
            end else begin
               bad = 0;
               for (int t = 0; t < FRAME; t++) if (smp[t] !== exp_bit(exp_b, t)) bad++;
               if (bad != 0) begin
                  errors++;
                  $display("FAIL rx_wave: %0d wrong samples for byte %02h, required 0", bad, exp_b);
               end
               checks++;
               if (got !== exp_b) begin
                  errors++;
                  $display("FAIL rx_byte: got %02h required %02h", got, exp_b);
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, output int k);
      int n;
      n = 0;
      @(negedge clk);
      i_data  = b;
      i_valid = 1'b1;
      while (o_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: o_ready stayed %b, required 1", o_ready);
      end
      k = cyc + 1;
      exp_q.push_back(b);
      @(posedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (o_busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL %s_idle_timeout: o_busy %b, required 0", name, o_busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (o_tx !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b required 1", o_tx); end
      checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
      checks++; if (o_level !== 3'd0)  begin errors++; $display("FAIL reset_level: got %0d required 0", o_level); end
      checks++; if (o_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b required 0", o_ready); end
      checks++; if (d2_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_def: got %b required 0", d2_ready); end
      checks++; if (d2_tx !== 1'b1)    begin errors++; $display("FAIL reset_tx_def: got %b required 1", d2_tx); end
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1)  begin errors++; $display("FAIL release_ready: got %b required 1", o_ready); end
      checks++; if (d2_ready !== 1'b1) begin errors++; $display("FAIL release_ready_def: got %b required 1", d2_ready); end
   endtask

   task automatic test_single_byte();
      int k;
      push_byte(8'hA5, k);
      @(negedge clk);
      i_valid = 1'b0;
      checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL single_tx_k: got %b required 1", o_tx); end
      checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL single_level_k: got %0d required 1", o_level); end
      checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL single_busy_k: got %b required 1", o_busy); end
      @(negedge clk);
      checks++; if (o_tx !== 1'b0)    begin errors++; $display("FAIL single_start_k1: got %b required 0", o_tx); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL single_level_k1: got %0d required 0", o_level); end
      while (cyc < k + 100) @(negedge clk);
      checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL single_busy_k100: got %b required 1", o_busy); end
      @(negedge clk);
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL single_busy_k101: got %b required 0", o_busy); end
      wait_idle("single");
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int k0, k1, k2;
      start_q.delete();
      push_byte(8'h00, k0);
      push_byte(8'hFF, k1);
      push_byte(8'h55, k2);
      @(negedge clk);
      i_valid = 1'b0;
      wait_idle("b2b");
      checks++;
      if (start_q.size() != 3) begin
         errors++;
         $display("FAIL b2b_frames: got %0d required 3", start_q.size());
      end else begin
         checks++; if (start_q[0] != k0 + 1) begin errors++; $display("FAIL b2b_first_start: got %0d required %0d", start_q[0], k0 + 1); end
         checks++; if (start_q[1] - start_q[0] != FRAME) begin errors++; $display("FAIL b2b_spacing1: got %0d required %0d", start_q[1] - start_q[0], FRAME); end
         checks++; if (start_q[2] - start_q[1] != FRAME) begin errors++; $display("FAIL b2b_spacing2: got %0d required %0d", start_q[2] - start_q[1], FRAME); end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_full_fifo();
      int         acc, n, f0, k0;
      logic [7:0] b;
      acc = 0; n = 0; k0 = 0; b = 8'h30;
      f0 = frames;
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = b;
      while (n < 50 && o_ready === 1'b1) begin
         if (acc == 0) k0 = cyc + 1;
         exp_q.push_back(b);
         acc++;
         b++;
         @(posedge clk);
         @(negedge clk);
         i_data = b;
         n++;
      end
      checks++; if (acc != 5)         begin errors++; $display("FAIL full_accepted: got %0d required 5", acc); end
      checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d required 4", o_level); end
      n = 0;
      while (o_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++; if (cyc != k0 + 101)  begin errors++; $display("FAIL full_ready_back: cycle %0d required %0d", cyc, k0 + 101); end
      checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL full_level_pop: got %0d required 3", o_level); end
      exp_q.push_back(b);
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      wait_idle("full");
      checks++; if (frames - f0 != 6)  begin errors++; $display("FAIL full_frames: got %0d required 6", frames - f0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_pending: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      int f0, k;
      f0 = frames;
      for (int i = 0; i < 20; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            i_valid = 1'b0;
         end
         push_byte(8'(i), k);
      end
      @(negedge clk);
      i_valid = 1'b0;
      wait_idle("wrap");
      checks++; if (frames - f0 != 20) begin errors++; $display("FAIL wrap_frames: got %0d required 20", frames - f0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d required 0", exp_q.size()); end
      checks++; if (o_level !== 3'd0)  begin errors++; $display("FAIL wrap_level: got %0d required 0", o_level); end
   endtask

   task automatic test_reset_mid_frame();
      int   k0, k1, k2, f0, s;
      logic hi_bad;
      push_byte(8'h3C, k0);
      push_byte(8'hC3, k1);
      push_byte(8'h99, k2);
      @(negedge clk);
      i_valid = 1'b0;
      s = k0 + 1;
      while (cyc < s + 43) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (o_tx !== 1'b1)    begin errors++; $display("FAIL midrst_tx: got %b required 1", o_tx); end
      checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d required 0", o_level); end
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b required 0", o_busy); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", o_ready); end
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b required 1", o_ready); end
      f0 = frames;
      hi_bad = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0) hi_bad = 1'b1;
      end
      checks++; if (hi_bad !== 1'b0) begin errors++; $display("FAIL midrst_quiet: line or busy active after release, required idle"); end
      checks++; if (frames != f0)    begin errors++; $display("FAIL midrst_frames: got %0d new frames required 0", frames - f0); end
   endtask

   task automatic test_default_params();
      int n, w;
      @(negedge clk);
      d2_data  = 8'hFF;
      d2_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d2_valid = 1'b0;
      n = 0;
      while (d2_tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      w = 0;
      while (d2_tx === 1'b0 && w < 500) begin
         w++;
         @(negedge clk);
      end
      checks++; if (w != 109) begin errors++; $display("FAIL default_start_width: got %0d cycles required 109", w); end
      n = 0;
      while (d2_busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (d2_busy !== 1'b0) begin errors++; $display("FAIL default_busy_end: got %b required 0", d2_busy); end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_full_fifo();
      test_wrap();
      test_reset_mid_frame();
      test_default_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
